// File: rtl/ram_client.sv
// ram_client: issues single read/write transactions to the ram responder over rq/ack.
// Define RAM_CLIENT_TIMEOUT_EN to abort a request that sees no ack within TIMEOUT cycles.
module ram_client #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr_ni,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rq,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  wr_ni,
    output logic [DATA_WIDTH-1:0] dataW,
    input  logic                  ack,
    input  logic [DATA_WIDTH-1:0] dataR
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_REL} state_t;

    state_t state;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("ram_client: TIMEOUT must be at least 2");
    end

    assign cmd_ready = (state == IDLE);

`ifdef RAM_CLIENT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rq        <= 1'b0;
            address   <= '0;
            wr_ni     <= 1'b1;
            dataW     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        address <= cmd_addr;
                        wr_ni   <= cmd_wr_ni;
                        dataW   <= cmd_wdata;
                        rq      <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    // ack on the expiry cycle still yields a normal response
                    if (ack) begin
                        rsp_rdata <= wr_ni ? dataR : '0;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rq        <= 1'b0;
                        state     <= WAIT_REL;
                    end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        rq        <= 1'b0;
                        state     <= WAIT_REL;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                WAIT_REL: begin
                    if (!ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign rsp_err = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rq        <= 1'b0;
            address   <= '0;
            wr_ni     <= 1'b1;
            dataW     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        address <= cmd_addr;
                        wr_ni   <= cmd_wr_ni;
                        dataW   <= cmd_wdata;
                        rq      <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (ack) begin
                        rsp_rdata <= wr_ni ? dataR : '0;
                        rsp_valid <= 1'b1;
                        rq        <= 1'b0;
                        state     <= WAIT_REL;
                    end
                end
                // ack lags rq by a cycle, so wait for it to fall before idling
                WAIT_REL: begin
                    if (!ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_ram_client.sv
// Directed self-checking bench for ram_client against a small behavioural ram responder.
// Timeout checks follow RAM_CLIENT_TIMEOUT_EN; without it REQ must wait indefinitely.
module tb_ram_client;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_wr_ni = 1'b1;
    logic [3:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rq;
    logic [3:0] address;
    logic       wr_ni;
    logic [7:0] dataW;
    logic       ack;
    logic [7:0] dataR = '0;

    int n_cmp = 0;
    int n_err = 0;

    // responder model: ack is a registered copy of rq, optionally delayed, held, or muted
    logic [7:0]  mem [16];
    logic        ram_ack = 1'b0;
    logic        ack_force = 1'b0;
    bit          ram_mute = 1'b0;
    int unsigned ram_delay = 0;
    int unsigned ram_linger = 0;
    int unsigned rq_cnt = 0;
    int unsigned linger_cnt = 0;

    assign ack = ram_ack | ack_force;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rq && !ram_mute) begin
            rq_cnt <= rq_cnt + 1;
            if (rq_cnt >= ram_delay) begin
                ram_ack    <= 1'b1;
                dataR      <= mem[address];
                linger_cnt <= ram_linger;
                if (!wr_ni) mem[address] <= dataW;
            end
        end else begin
            rq_cnt <= 0;
            if (ram_ack && linger_cnt > 0) linger_cnt <= linger_cnt - 1;
            else ram_ack <= 1'b0;
        end
    end

    ram_client #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_ni(cmd_wr_ni),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rq(rq), .address(address), .wr_ni(wr_ni), .dataW(dataW),
        .ack(ack), .dataR(dataR)
    );

    // Presents a command at a negedge and returns at the negedge after it is accepted.
    task automatic issue(input logic wn, input logic [3:0] a, input logic [7:0] d);
        cmd_wr_ni = wn; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (rq !== 1'b0) begin n_err++; $display("FAIL reset_rq: got %b want 0", rq); end
        n_cmp++; if (address !== 4'h0) begin n_err++; $display("FAIL reset_address: got %h want 0", address); end
        n_cmp++; if (wr_ni !== 1'b1) begin n_err++; $display("FAIL reset_wr_ni: got %b want 1", wr_ni); end
        n_cmp++; if (dataW !== 8'h00) begin n_err++; $display("FAIL reset_dataW: got %h want 00", dataW); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rsp_rdata: got %h want 00", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_write_read();
        issue(1'b0, 4'h3, 8'hA5);
        n_cmp++; if (rq !== 1'b1) begin n_err++; $display("FAIL wr_rq: got %b want 1", rq); end
        n_cmp++; if (address !== 4'h3) begin n_err++; $display("FAIL wr_address: got %h want 3", address); end
        n_cmp++; if (wr_ni !== 1'b0) begin n_err++; $display("FAIL wr_wr_ni: got %b want 0", wr_ni); end
        n_cmp++; if (dataW !== 8'hA5) begin n_err++; $display("FAIL wr_dataW: got %h want a5", dataW); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL wr_busy: got %b want 0", cmd_ready); end
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_early_rsp: got %b want 0", rsp_valid); end
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL wr_rsp_valid: got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 8'h00) begin n_err++; $display("FAIL wr_rsp_rdata: got %h want 00", rsp_rdata); end
        n_cmp++; if (rq !== 1'b0) begin n_err++; $display("FAIL wr_rq_drop: got %b want 0", rq); end
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_rsp_width: got %b want 0", rsp_valid); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL wr_wait_rel: got %b want 0", cmd_ready); end
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL wr_idle: got %b want 1", cmd_ready); end

        issue(1'b1, 4'h3, 8'h00);
        repeat (2) @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rd_rsp_valid: got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 8'hA5) begin n_err++; $display("FAIL rd_rsp_rdata: got %h want a5", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL rd_rsp_err: got %b want 0", rsp_err); end
        @(negedge clk);
        n_cmp++; if (rsp_rdata !== 8'hA5) begin n_err++; $display("FAIL rd_rdata_hold: got %h want a5", rsp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_idle_ack();
        int bad = 0;
        ack_force = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
        end
        ack_force = 1'b0;
        @(negedge clk);
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL idle_ack_ignored: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] addrs [3];
        logic [7:0] exp [3];
        int n_rsp = 0, issued = 1, lows = 0, gaps = 0;
        int gap_len [2];
        addrs[0] = 4'h5; addrs[1] = 4'h6; addrs[2] = 4'h7;
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        mem[5] = 8'h11; mem[6] = 8'h22; mem[7] = 8'h33;
        gap_len[0] = -1; gap_len[1] = -1;
        cmd_wr_ni = 1'b1; cmd_addr = addrs[0]; cmd_valid = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                n_cmp++;
                if (n_rsp > 2 || rsp_rdata !== exp[n_rsp > 2 ? 2 : n_rsp]) begin
                    n_err++; $display("FAIL b2b_rdata[%0d]: got %h want %h", n_rsp, rsp_rdata, exp[n_rsp > 2 ? 2 : n_rsp]);
                end
                n_rsp++;
            end
            if (cmd_ready) begin
                if (gaps < 2 && cmd_valid) gap_len[gaps] = lows;
                if (cmd_valid) gaps++;
                lows = 0;
                if (issued < 3) begin cmd_addr = addrs[issued]; issued++; end
                else cmd_valid = 1'b0;
            end else begin
                lows++;
            end
        end
        cmd_valid = 1'b0;
        n_cmp++; if (n_rsp !== 3) begin n_err++; $display("FAIL b2b_rsp_count: got %0d want 3", n_rsp); end
        n_cmp++; if (gap_len[0] !== 4) begin n_err++; $display("FAIL b2b_gap0: got %0d busy cycles want 4", gap_len[0]); end
        n_cmp++; if (gap_len[1] !== 4) begin n_err++; $display("FAIL b2b_gap1: got %0d busy cycles want 4", gap_len[1]); end
    endtask

    task automatic test_stall();
        int bad = 0, ack_c = -1, rsp_c = -1, n_rsp = 0;
        mem[9] = 8'h5C;
        ram_delay = 5;
        issue(1'b1, 4'h9, 8'h00);
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid) begin n_rsp++; if (rsp_c < 0) rsp_c = c; end
            else if (rsp_c < 0 && (rq !== 1'b1 || address !== 4'h9 || wr_ni !== 1'b1)) bad++;
            if (ack && ack_c < 0) ack_c = c;
            if (rsp_valid) begin
                n_cmp++; if (rsp_rdata !== 8'h5C) begin n_err++; $display("FAIL stall_rdata: got %h want 5c", rsp_rdata); end
            end
        end
        ram_delay = 0;
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL stall_hold: got %0d unstable cycles want 0", bad); end
        n_cmp++; if (n_rsp !== 1) begin n_err++; $display("FAIL stall_rsp_count: got %0d want 1", n_rsp); end
        n_cmp++; if (ack_c < 0 || rsp_c - ack_c !== 1) begin n_err++; $display("FAIL stall_latency: got ack@%0d rsp@%0d want rsp one after ack", ack_c, rsp_c); end
    endtask

    task automatic test_timeout();
        int n_rq = 0, got = 0, bad = 0;
        ram_mute = 1'b1;
        issue(1'b1, 4'h3, 8'h00);
`ifdef RAM_CLIENT_TIMEOUT_EN
        if (rq) n_rq++;
        for (int c = 0; c < 40 && got == 0; c++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
            else if (rq) n_rq++;
        end
        n_cmp++; if (got !== 1) begin n_err++; $display("FAIL tmo_rsp_valid: got %0d want 1", got); end
        n_cmp++; if (n_rq !== 16) begin n_err++; $display("FAIL tmo_req_cycles: got %0d want 16", n_rq); end
        n_cmp++; if (rsp_err !== 1'b1) begin n_err++; $display("FAIL tmo_rsp_err: got %b want 1", rsp_err); end
        n_cmp++; if (rsp_rdata !== 8'h00) begin n_err++; $display("FAIL tmo_rsp_rdata: got %h want 00", rsp_rdata); end
        n_cmp++; if (rq !== 1'b0) begin n_err++; $display("FAIL tmo_rq_drop: got %b want 0", rq); end
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL tmo_idle: got %b want 1", cmd_ready); end
        ram_mute = 1'b0;
`else
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid) got++;
            if (rq !== 1'b1 || rsp_err !== 1'b0) bad++;
        end
        n_cmp++; if (got !== 0) begin n_err++; $display("FAIL notmo_rsp: got %0d want 0", got); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL notmo_hold: got %0d bad cycles want 0", bad); end
        ram_mute = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif
        issue(1'b1, 4'h3, 8'h00);
        repeat (2) @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_err++; $display("FAIL post_tmo_rsp: got valid %b err %b want 1 0", rsp_valid, rsp_err); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_req();
        int got = 0;
        ram_mute = 1'b1;
        issue(1'b1, 4'h3, 8'h00);
        @(negedge clk);
        n_cmp++; if (rq !== 1'b1) begin n_err++; $display("FAIL rst_pre_rq: got %b want 1", rq); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rq !== 1'b0) begin n_err++; $display("FAIL rst_rq_async: got %b want 0", rq); end
        ram_mute = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rsp_valid) got++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (rsp_valid) got++;
        n_cmp++; if (got !== 0) begin n_err++; $display("FAIL rst_no_rsp: got %0d want 0", got); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
        issue(1'b1, 4'h3, 8'h00);
        repeat (2) @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin n_err++; $display("FAIL rst_recover: got valid %b data %h want 1 a5", rsp_valid, rsp_rdata); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lingering_ack();
        int extra = 0, ready_hi = 0;
        ram_linger = 2;
        issue(1'b1, 4'h3, 8'h00);
        repeat (2) @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL linger_rsp: got %b want 1", rsp_valid); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rsp_valid) extra++;
            if (cmd_ready) ready_hi++;
        end
        ram_linger = 0;
        n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL linger_extra_rsp: got %0d want 0", extra); end
        n_cmp++; if (ready_hi !== 0) begin n_err++; $display("FAIL linger_ready: got %0d ready cycles want 0", ready_hi); end
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL linger_idle: got %b want 1", cmd_ready); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
        test_reset();
        test_write_read();
        test_idle_ack();
        test_back_to_back();
        test_stall();
        test_timeout();
        test_reset_mid_req();
        test_lingering_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
